// File: rtl/tff_updown_counter_if.sv
// Control and status bundle for the T flip-flop up/down counter.
// The master drives the count controls and the slave (the counter) returns the count and flags.
interface tff_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, d,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up, load, d,
        output q, tc, wrap
    );
endinterface

// File: rtl/tff_updown_counter.sv
// Synchronous up/down counter built from per-bit T flip-flops, with parallel load,
// a combinational terminal-count flag and a registered wrap pulse.
module tff_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    tff_updown_counter_if.slave bus
);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] carry_up_s;
    logic [WIDTH-1:0] carry_dn_s;
    logic [WIDTH-1:0] t_s;
    logic             tc_s;

    // Toggle network: bit i toggles when all lower bits are ones (up) or zeros (down).
    always_comb begin
        carry_up_s    = {WIDTH{1'b0}};
        carry_dn_s    = {WIDTH{1'b0}};
        t_s           = {WIDTH{1'b0}};
        carry_up_s[0] = 1'b1;
        carry_dn_s[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry_up_s[i] = carry_up_s[i-1] & q_r[i-1];
            carry_dn_s[i] = carry_dn_s[i-1] & ~q_r[i-1];
        end
        if (bus.en) begin
            if (bus.up) begin
                t_s = carry_up_s;
            end else begin
                t_s = carry_dn_s;
            end
        end else begin
            t_s = {WIDTH{1'b0}};
        end
    end

    // Terminal count: the next enabled step crosses the boundary; suppressed during load.
    always_comb begin
        tc_s = 1'b0;
        if (bus.load) begin
            tc_s = 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                tc_s = &q_r;
            end else begin
                tc_s = ~|q_r;
            end
        end else begin
            tc_s = 1'b0;
        end
    end

    // Count state and wrap pulse; load bypasses the toggle network.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r    <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
        end else if (bus.load) begin
            q_r    <= bus.d;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_r ^ t_s;
            wrap_r <= tc_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.tc   = tc_s;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Scoreboard bench for tff_updown_counter at WIDTH = 4 and WIDTH = 8.
module tb_tff_updown_counter;

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       wrap;
    } exp_t;

    logic clk;
    logic reset;
    logic done;
    int   n_cmp;
    int   n_err;
    int   step4;
    int   step8;
    exp_t sb4[$];
    exp_t sb8[$];
    exp_t e4;
    exp_t e8;

    tff_updown_counter_if #(.WIDTH(4)) if4 ();
    tff_updown_counter_if #(.WIDTH(8)) if8 ();

    tff_updown_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    tff_updown_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per DUT per falling edge and compares.
    always @(negedge clk) begin
        if (sb4.size() > 0) begin
            e4 = sb4.pop_front();
            step4++;
            n_cmp++;
            if (if4.q !== e4.q[3:0] || if4.tc !== e4.tc || if4.wrap !== e4.wrap) begin
                n_err++;
                $display("FAIL w4_step%0d: got q=%0h tc=%b wrap=%b, expected q=%0h tc=%b wrap=%b",
                         step4, if4.q, if4.tc, if4.wrap, e4.q[3:0], e4.tc, e4.wrap);
            end
        end
        if (sb8.size() > 0) begin
            e8 = sb8.pop_front();
            step8++;
            n_cmp++;
            if (if8.q !== e8.q || if8.tc !== e8.tc || if8.wrap !== e8.wrap) begin
                n_err++;
                $display("FAIL w8_step%0d: got q=%0h tc=%b wrap=%b, expected q=%0h tc=%b wrap=%b",
                         step8, if8.q, if8.tc, if8.wrap, e8.q, e8.tc, e8.wrap);
            end
        end
        if (done) begin
            n_cmp++;
            if (sb4.size() != 0 || sb8.size() != 0) begin
                n_err++;
                $display("FAIL drain: got %0d/%0d pending, expected 0/0", sb4.size(), sb8.size());
            end
        end
    end

    task automatic cyc4(input logic r, input logic e, input logic u, input logic l,
                        input logic [3:0] dv, input logic [3:0] eq,
                        input logic et, input logic ew);
        @(posedge clk);
        #1;
        reset    = r;
        if4.en   = e;
        if4.up   = u;
        if4.load = l;
        if4.d    = dv;
        sb4.push_back('{q: {4'h0, eq}, tc: et, wrap: ew});
    endtask

    task automatic cyc8(input logic e, input logic u, input logic l,
                        input logic [7:0] dv, input logic [7:0] eq,
                        input logic et, input logic ew);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        if8.en   = e;
        if8.up   = u;
        if8.load = l;
        if8.d    = dv;
        sb8.push_back('{q: eq, tc: et, wrap: ew});
    endtask

    initial begin
        n_cmp = 0; n_err = 0; step4 = 0; step8 = 0; done = 1'b0;
        reset = 1'b0;
        if4.en = 1'b0; if4.up = 1'b0; if4.load = 1'b0; if4.d = 4'h0;
        if8.en = 1'b0; if8.up = 1'b0; if8.load = 1'b0; if8.d = 8'h00;

        // Reset state; tc follows its equation during reset (q = 0, down).
        cyc4(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        // Up count through the 15 -> 0 boundary.
        for (int i = 1; i <= 20; i++) begin
            cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'(i % 16), (i % 16) == 15, (i % 16) == 0);
        end
        // Hold for three cycles at 5, then down two, then up one.
        cyc4(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
        cyc4(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
        cyc4(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0);
        // Load priority over en, including at the all-ones boundary.
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h6, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 4'h7, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hC, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hD, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'hF, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0);
        // Down count through the 0 -> 15 boundary, twice.
        cyc4(1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 4'h4, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0);
        for (int v = 13; v >= 0; v--) begin
            cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'(v), v == 0, 1'b0);
        end
        cyc4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
        // Reach 9 and assert reset between edges.
        cyc4(1'b1, 1'b1, 1'b1, 1'b1, 4'h8, 4'hE, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb4.push_back('{q: 8'h00, tc: 1'b0, wrap: 1'b0});
        cyc4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0);

        // WIDTH = 8 boundary from 8'hFE.
        cyc8(1'b0, 1'b1, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0);
        cyc8(1'b1, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0);
        cyc8(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
        cyc8(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cyc8(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        cyc8(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);

        @(posedge clk);
        @(posedge clk);
        done = 1'b1;
        @(posedge clk);
        done = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
